// File: rtl/omp_pkg.sv
// Shared types and sizing for the OMP host sequencer and the core wrapper.
// Sequencer states, readback-slot phases, address widths and default frame sizes.
package omp_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned Q_AW    = 15;
  localparam int unsigned X_AW    = 8;
  localparam int unsigned V_AW    = 7;

  localparam int unsigned N_Q_DEF = 3200;
  localparam int unsigned N_X_DEF = 100;
  localparam int unsigned K_DEF   = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_Q  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RD_LEN  = 3'd5,
    ST_RD_SUPP = 3'd6,
    ST_RD_V    = 3'd7
  } omp_seq_state_t;

  typedef enum logic [1:0] {
    SL_IDLE = 2'd0,
    SL_MEM  = 2'd1,
    SL_CAP  = 2'd2,
    SL_HOLD = 2'd3
  } omp_slot_phase_t;

  // Number of support/V words actually streamed: the reported length, capped at K.
  function automatic logic [7:0] clamp_len(input logic [31:0] len, input logic [7:0] k);
    logic [7:0] n;
    if (len > {24'd0, k}) begin
      n = k;
    end else begin
      n = len[7:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/omp_host_seq_if.sv
// Input and result stream bundle between the host and the OMP sequencer.
// slave is the sequencer side, master the host side.
interface omp_host_seq_if;

  logic [omp_pkg::DATA_W-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [omp_pkg::DATA_W-1:0] m_data;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/omp_rd_slot.sv
// One readback phase: issue address, wait for the synchronous memory, capture, hold until consumed.
// The next address is only issued once the presented word has been taken.
module omp_rd_slot
  import omp_pkg::*;
#(
  parameter bit FINAL_PHASE = 1'b0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      n,
  input  logic            m_ready,
  output logic [V_AW-1:0] addr,
  output logic            cap,
  output logic            frame_last,
  output logic            done
);

  omp_slot_phase_t phase_r;
  omp_slot_phase_t phase_next_s;
  logic [V_AW-1:0] addr_r;
  logic [V_AW-1:0] addr_next_s;
  logic            take_s;
  logic            last_s;

  // Phase sequencing and address advance.
  always_comb begin
    phase_next_s = phase_r;
    addr_next_s  = addr_r;
    take_s       = 1'b0;
    last_s       = ({1'b0, addr_r} == (n - 8'd1));
    case (phase_r)
      SL_IDLE: begin
        if (start) begin
          phase_next_s = SL_MEM;
          addr_next_s  = 7'd0;
        end else begin
          phase_next_s = SL_IDLE;
        end
      end
      SL_MEM:  phase_next_s = SL_CAP;
      SL_CAP:  phase_next_s = SL_HOLD;
      SL_HOLD: begin
        take_s = m_ready;
        if (m_ready && last_s) begin
          phase_next_s = SL_IDLE;
        end else if (m_ready) begin
          phase_next_s = SL_MEM;
          addr_next_s  = addr_r + 7'd1;
        end else begin
          phase_next_s = SL_HOLD;
        end
      end
      default: phase_next_s = SL_IDLE;
    endcase
  end

  // Phase and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= SL_IDLE;
      addr_r  <= 7'd0;
    end else begin
      phase_r <= phase_next_s;
      addr_r  <= addr_next_s;
    end
  end

  assign addr       = addr_r;
  assign cap        = (phase_r == SL_CAP);
  assign frame_last = FINAL_PHASE & last_s;
  assign done       = take_s & last_s;

endmodule

// File: rtl/omp_host_seq.sv
// Host-side sequencer: loads one frame into the core's Q/X memories, runs the core,
// then streams support length, support indices and coefficients back out.
module omp_host_seq
  import omp_pkg::*;
#(
  parameter int unsigned N_Q = N_Q_DEF,
  parameter int unsigned N_X = N_X_DEF,
  parameter int unsigned K   = K_DEF
)(
  input  logic              clk,
  input  logic              rst,
  omp_host_seq_if.slave     bus,
  output logic              busy,
  output logic [Q_AW-1:0]   Q_address_in,
  output logic [DATA_W-1:0] datain,
  output logic              Q_we_in,
  output logic [X_AW-1:0]   X_address0_in,
  output logic [DATA_W-1:0] X_d0_in,
  output logic              X_we0_in,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_idle,
  output logic [V_AW-1:0]   supp_address0_in,
  input  logic [DATA_W-1:0] supp_q0,
  output logic [V_AW-1:0]   V_address0_in,
  input  logic [DATA_W-1:0] V_q0,
  input  logic [DATA_W-1:0] supp_len
);

  localparam logic [Q_AW-1:0] Q_LAST = Q_AW'(N_Q - 1);
  localparam logic [X_AW-1:0] X_LAST = X_AW'(N_X - 1);
  localparam logic [7:0]      K_N    = 8'(K);

  omp_seq_state_t    state_r;
  omp_seq_state_t    state_next_s;

  logic              s_ready_r;
  logic [DATA_W-1:0] m_data_r;
  logic              m_valid_r;
  logic              m_last_r;
  logic              busy_r;
  logic              ap_start_r;
  logic [Q_AW-1:0]   q_addr_r;
  logic [DATA_W-1:0] q_data_r;
  logic              q_we_r;
  logic [X_AW-1:0]   x_addr_r;
  logic [DATA_W-1:0] x_data_r;
  logic              x_we_r;
  logic [Q_AW-1:0]   qcnt_r;
  logic [X_AW-1:0]   xcnt_r;
  logic [7:0]        n_r;

  logic              accept_s;
  logic              out_take_s;
  logic              supp_start_s;
  logic              v_start_s;
  logic              supp_cap_s;
  logic              supp_flast_s;
  logic              supp_done_s;
  logic              v_cap_s;
  logic              v_flast_s;
  logic              v_done_s;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_next_s = state_r;
    accept_s     = s_ready_r & bus.s_valid;
    out_take_s   = m_valid_r & bus.m_ready;
    supp_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ap_idle) state_next_s = ST_LOAD_Q;
        else         state_next_s = ST_IDLE;
      end
      ST_LOAD_Q: begin
        if (accept_s && (qcnt_r == Q_LAST)) state_next_s = ST_LOAD_X;
        else                                state_next_s = ST_LOAD_Q;
      end
      ST_LOAD_X: begin
        if (accept_s && (xcnt_r == X_LAST)) state_next_s = ST_START;
        else                                state_next_s = ST_LOAD_X;
      end
      ST_START: begin
        if (!ap_idle) state_next_s = ST_WAIT;
        else          state_next_s = ST_START;
      end
      ST_WAIT: begin
        if (ap_done) state_next_s = ST_RD_LEN;
        else         state_next_s = ST_WAIT;
      end
      ST_RD_LEN: begin
        if (out_take_s && (n_r == 8'd0)) begin
          state_next_s = ST_IDLE;
        end else if (out_take_s) begin
          state_next_s = ST_RD_SUPP;
          supp_start_s = 1'b1;
        end else begin
          state_next_s = ST_RD_LEN;
        end
      end
      ST_RD_SUPP: begin
        if (supp_done_s) state_next_s = ST_RD_V;
        else             state_next_s = ST_RD_SUPP;
      end
      ST_RD_V: begin
        if (v_done_s) state_next_s = ST_IDLE;
        else          state_next_s = ST_RD_V;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign v_start_s = (state_r == ST_RD_SUPP) & supp_done_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Load path: one registered write per accepted word, counters hold on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_addr_r <= 15'd0;
      q_data_r <= 32'd0;
      q_we_r   <= 1'b0;
      x_addr_r <= 8'd0;
      x_data_r <= 32'd0;
      x_we_r   <= 1'b0;
      qcnt_r   <= 15'd0;
      xcnt_r   <= 8'd0;
    end else begin
      q_we_r <= 1'b0;
      x_we_r <= 1'b0;
      if ((state_r == ST_LOAD_Q) && accept_s) begin
        q_addr_r <= qcnt_r;
        q_data_r <= bus.s_data;
        q_we_r   <= 1'b1;
        qcnt_r   <= (qcnt_r == Q_LAST) ? 15'd0 : (qcnt_r + 15'd1);
      end else if ((state_r == ST_LOAD_X) && accept_s) begin
        x_addr_r <= xcnt_r;
        x_data_r <= bus.s_data;
        x_we_r   <= 1'b1;
        xcnt_r   <= (xcnt_r == X_LAST) ? 8'd0 : (xcnt_r + 8'd1);
      end else if (state_r == ST_IDLE) begin
        qcnt_r <= 15'd0;
        xcnt_r <= 8'd0;
      end
    end
  end

  // Control outputs follow the state being entered so they are valid in that state's first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_r  <= 1'b0;
      ap_start_r <= 1'b0;
      busy_r     <= 1'b0;
      n_r        <= 8'd0;
    end else begin
      s_ready_r  <= (state_next_s == ST_LOAD_Q) || (state_next_s == ST_LOAD_X);
      ap_start_r <= (state_next_s == ST_START);
      busy_r     <= (state_next_s != ST_IDLE);
      if ((state_r == ST_WAIT) && ap_done) begin
        n_r <= clamp_len(supp_len, K_N);
      end
    end
  end

  // Result stream register; the raw length is sent even when the word count is clamped.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_r  <= 32'd0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if ((state_r == ST_WAIT) && ap_done) begin
      m_data_r  <= supp_len;
      m_valid_r <= 1'b1;
      m_last_r  <= (clamp_len(supp_len, K_N) == 8'd0);
    end else if (supp_cap_s) begin
      m_data_r  <= supp_q0;
      m_valid_r <= 1'b1;
      m_last_r  <= supp_flast_s;
    end else if (v_cap_s) begin
      m_data_r  <= V_q0;
      m_valid_r <= 1'b1;
      m_last_r  <= v_flast_s;
    end else if (out_take_s) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  omp_rd_slot #(.FINAL_PHASE(1'b0)) u_supp_slot (
    .clk        (clk),
    .rst        (rst),
    .start      (supp_start_s),
    .n          (n_r),
    .m_ready    (bus.m_ready),
    .addr       (supp_address0_in),
    .cap        (supp_cap_s),
    .frame_last (supp_flast_s),
    .done       (supp_done_s)
  );

  omp_rd_slot #(.FINAL_PHASE(1'b1)) u_v_slot (
    .clk        (clk),
    .rst        (rst),
    .start      (v_start_s),
    .n          (n_r),
    .m_ready    (bus.m_ready),
    .addr       (V_address0_in),
    .cap        (v_cap_s),
    .frame_last (v_flast_s),
    .done       (v_done_s)
  );

  assign bus.s_ready   = s_ready_r;
  assign bus.m_data    = m_data_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_last    = m_last_r;
  assign busy          = busy_r;
  assign ap_start      = ap_start_r;
  assign Q_address_in  = q_addr_r;
  assign datain        = q_data_r;
  assign Q_we_in       = q_we_r;
  assign X_address0_in = x_addr_r;
  assign X_d0_in       = x_data_r;
  assign X_we0_in      = x_we_r;

endmodule

// File: tb/tb_omp_host_seq.sv
// Randomized scoreboard bench for omp_host_seq with a behavioural core model.
// Expected writes and result words are queued at stimulus time and popped by a monitor.
module tb_omp_host_seq;
  import omp_pkg::*;

  localparam int unsigned NQ = 32;
  localparam int unsigned NX = 4;
  localparam int unsigned KK = 100;
  localparam int unsigned NW = NQ + NX;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [Q_AW-1:0]   Q_address_in;
  logic [DATA_W-1:0] datain;
  logic              Q_we_in;
  logic [X_AW-1:0]   X_address0_in;
  logic [DATA_W-1:0] X_d0_in;
  logic              X_we0_in;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic [V_AW-1:0]   supp_address0_in;
  logic [DATA_W-1:0] supp_q0;
  logic [V_AW-1:0]   V_address0_in;
  logic [DATA_W-1:0] V_q0;
  logic [DATA_W-1:0] supp_len;

  always #5 clk = ~clk;

  omp_host_seq_if bus ();

  omp_host_seq #(.N_Q(NQ), .N_X(NX), .K(KK)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .busy             (busy),
    .Q_address_in     (Q_address_in),
    .datain           (datain),
    .Q_we_in          (Q_we_in),
    .X_address0_in    (X_address0_in),
    .X_d0_in          (X_d0_in),
    .X_we0_in         (X_we0_in),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .supp_address0_in (supp_address0_in),
    .supp_q0          (supp_q0),
    .V_address0_in    (V_address0_in),
    .V_q0             (V_q0),
    .supp_len         (supp_len)
  );

  // Core model: synchronous readback memories and a start/done handshake with a random run time.
  logic [31:0] supp_mem [128];
  logic [31:0] v_mem    [128];
  logic [31:0] cfg_len;
  int          done_dly;
  int          run_cnt;

  assign supp_len = cfg_len;

  always @(posedge clk) begin
    supp_q0 <= supp_mem[supp_address0_in];
    V_q0    <= v_mem[V_address0_in];
    if (rst) begin
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      run_cnt <= 0;
    end else begin
      ap_done <= 1'b0;
      if (ap_idle && ap_start) begin
        ap_idle <= 1'b0;
        run_cnt <= done_dly;
      end else if (!ap_idle) begin
        if (run_cnt == 0) begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
        end else begin
          run_cnt <= run_cnt - 1;
        end
      end
    end
  end

  typedef struct { bit is_x; int unsigned addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; bit last; } out_t;

  wr_t  wq[$];
  out_t oq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;
  int rdy_mode = 0;
  bit stall_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Monitor: write scoreboard, write latency, result scoreboard and hold stability.
  initial begin
    bit          acc_prev;
    bit          hold_v;
    logic [32:0] hold_word;
    wr_t         w;
    out_t        o;
    acc_prev = 1'b0;
    hold_v   = 1'b0;
    hold_word = 33'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_prev = 1'b0;
        hold_v   = 1'b0;
      end else begin
        if (Q_we_in || X_we0_in || acc_prev)
          check("write_one_cycle_after_accept", {63'd0, Q_we_in | X_we0_in}, {63'd0, acc_prev});
        if (Q_we_in) begin
          if (wq.size() == 0) fail_now("unexpected_q_write");
          else begin
            w = wq.pop_front();
            check("q_write_port", {X_we0_in, 1'b0, Q_address_in, datain},
                  {w.is_x, 1'b0, 15'(w.addr), w.data});
          end
        end else if (X_we0_in) begin
          if (wq.size() == 0) fail_now("unexpected_x_write");
          else begin
            w = wq.pop_front();
            check("x_write_port", {1'b1, 7'd0, X_address0_in, X_d0_in},
                  {w.is_x, 7'd0, 8'(w.addr), w.data});
          end
        end
        acc_prev = bus.s_valid && bus.s_ready;

        if (hold_v && bus.m_valid)
          check("m_data_stable_while_stalled", {31'd0, bus.m_last, bus.m_data}, {31'd0, hold_word});
        hold_v    = bus.m_valid && !bus.m_ready;
        hold_word = {bus.m_last, bus.m_data};

        if (bus.m_valid && bus.m_ready) begin
          if (oq.size() == 0) fail_now("unexpected_output_word");
          else begin
            o = oq.pop_front();
            check("m_data", {32'd0, bus.m_data}, {32'd0, o.data});
            check("m_last", {63'd0, bus.m_last}, {63'd0, o.last});
          end
          out_cnt++;
        end
      end
    end
  end

  // Result-side backpressure: always ready, random, or a single 5-cycle stall on word 2.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2 && out_cnt == 2 && bus.m_valid && !stall_done) begin
        bus.m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        stall_done = 1'b1;
      end else if (rdy_mode == 1) begin
        bus.m_ready = ($urandom_range(0, 1) == 1);
      end else begin
        bus.m_ready = 1'b1;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl_zero"},
          {57'd0, bus.s_ready, bus.m_valid, bus.m_last, busy, Q_we_in, X_we0_in, ap_start}, 64'd0);
    check({tag, "_bus_zero"},
          {63'd0, |{bus.m_data, Q_address_in, datain, X_address0_in, X_d0_in,
                    supp_address0_in, V_address0_in}}, 64'd0);
  endtask

  // One frame: vmode 0 continuous, 1 toggling, 2 random valid; abort resets after two X words.
  task automatic run_frame(input bit seq, input int vmode, input logic [31:0] len,
                           input int rmode, input bit abort);
    logic [31:0] words [NW];
    int          n, nacc, budget;
    bit          acc, tog, ap_prev, all_in;
    wr_t         w;
    out_t        o;

    n = (len > 32'(KK)) ? KK : int'(len);
    for (int i = 0; i < int'(NW); i++) words[i] = seq ? 32'(i) : $urandom;
    for (int i = 0; i < 128; i++) begin
      supp_mem[i] = $urandom_range(0, NX - 1);
      v_mem[i]    = $urandom;
    end
    if (seq) begin
      supp_mem[0] = 32'd7;  supp_mem[1] = 32'd2;  supp_mem[2] = 32'd9;
      v_mem[0]    = 32'hA;  v_mem[1]    = 32'hB;  v_mem[2]    = 32'hC;
    end
    cfg_len    = len;
    done_dly   = $urandom_range(1, 8);
    rdy_mode   = rmode;
    stall_done = 1'b0;
    out_cnt    = 0;

    nacc = abort ? int'(NQ) + 2 : int'(NW);
    for (int i = 0; i < nacc; i++) begin
      w.is_x = (i >= int'(NQ));
      w.addr = (i < int'(NQ)) ? i : i - NQ;
      w.data = words[i];
      wq.push_back(w);
    end
    if (!abort) begin
      o.data = len; o.last = (n == 0); oq.push_back(o);
      for (int i = 0; i < n; i++) begin o.data = supp_mem[i]; o.last = 1'b0; oq.push_back(o); end
      for (int i = 0; i < n; i++) begin o.data = v_mem[i]; o.last = (i == n - 1); oq.push_back(o); end
    end

    tog = 1'b1;
    all_in = 1'b1;
    ap_prev = 1'b0;
    for (int j = 0; j < nacc; j++) begin
      budget = 200;
      acc = 1'b0;
      while (!acc && budget > 0) begin
        case (vmode)
          0:       bus.s_valid = 1'b1;
          1:       begin bus.s_valid = tog; tog = !tog; end
          default: bus.s_valid = ($urandom_range(0, 3) != 0);
        endcase
        bus.s_data = bus.s_valid ? words[j] : $urandom;
        @(negedge clk);
        acc = bus.s_valid && bus.s_ready;
        ap_prev = ap_start;
        @(posedge clk);
        #1;
        budget--;
      end
      if (!acc) begin
        fail_now("load_accept_timeout");
        all_in = 1'b0;
        break;
      end
    end
    bus.s_valid = 1'b0;

    if (abort) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("mid_load_reset");
      rst = 1'b0;
      wq.delete();
      oq.delete();
      return;
    end

    if (all_in) begin
      @(negedge clk);
      check("ap_start_rise_after_last_accept", {62'd0, ap_prev, ap_start}, 64'd1);
    end

    budget = 3000;
    while (oq.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (oq.size() != 0) begin
      fail_now("readback_timeout");
      oq.delete();
    end
    @(negedge clk);
    check("idle_after_frame", {62'd0, busy, bus.m_valid}, 64'd0);
    check("all_writes_seen", 64'(wq.size()), 64'd0);
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] len;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'd0;
    cfg_len  = 32'd0;
    done_dly = 2;
    for (int i = 0; i < 128; i++) begin supp_mem[i] = 32'd0; v_mem[i] = 32'd0; end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("power_on_reset");
    rst = 1'b0;

    run_frame(1'b1, 0, 32'd3,   2, 1'b0);   // load 0..35, readback 3,7,2,9,A,B,C with stall
    run_frame(1'b1, 1, 32'd0,   0, 1'b0);   // toggling valid, empty support
    run_frame(1'b0, 2, 32'd200, 1, 1'b0);   // clamp to K
    run_frame(1'b1, 0, 32'd5,   0, 1'b1);   // reset during X load
    run_frame(1'b1, 0, 32'd5,   1, 1'b0);   // fresh frame from Q address 0
    for (int f = 0; f < 5; f++) begin
      case ($urandom_range(0, 3))
        0:       len = 32'd0;
        1:       len = 32'h0001_0005;
        2:       len = $urandom_range(KK + 1, 255);
        default: len = $urandom_range(1, KK);
      endcase
      run_frame(1'b0, 2, len, 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
